// File: rtl/fsm_par_framer.sv
// fsm_par_framer: frames a byte stream into header / parity-tagged data / checksum trailer words
module fsm_par_framer #(
    parameter int PKT_LEN = 4,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [15:0] bus_data_out,
    output logic        bus_valid,
    output logic [1:0]  state,
    output logic        error
);
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, TRAILER = 2'd2, ABORT = 2'd3} state_t;

    localparam logic [3:0] LEN     = 4'(PKT_LEN);
    localparam logic [3:0] LAST    = 4'(PKT_LEN - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      st, st_nx;
    logic [3:0]  seq, seq_nx, cnt, cnt_nx;
    logic [7:0]  csum, csum_nx, stall, stall_nx;
    logic [15:0] bus_nx;
    logic        valid_nx, err_nx, accept;

    assign data_ready = (st == DATA);
    assign accept     = data_valid & data_ready;
    assign state      = st;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= IDLE;
        else        st <= st_nx;
    end

    // next-state: a stalled DATA state gives up after TIMEOUT consecutive idle edges
    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = data_valid ? DATA : IDLE;
            DATA:    st_nx = accept ? ((cnt == LAST) ? TRAILER : DATA)
                                    : ((stall == TO_LAST) ? ABORT : DATA);
            default: st_nx = IDLE;
        endcase
    end

    // output / datapath next values; bus defaults to an empty bubble
    always_comb begin
        bus_nx   = '0;
        valid_nx = 1'b0;
        err_nx   = error;
        seq_nx   = seq;
        cnt_nx   = cnt;
        csum_nx  = csum;
        stall_nx = stall;
        case (st)
            IDLE: if (data_valid) begin
                bus_nx   = {4'hA, seq, 4'h0, LEN};
                valid_nx = 1'b1;
                err_nx   = 1'b0;
                cnt_nx   = '0;
                csum_nx  = '0;
                stall_nx = '0;
            end
            DATA: if (accept) begin
                bus_nx   = {4'h5, 3'b000, ^data_in, data_in};
                valid_nx = 1'b1;
                csum_nx  = csum + data_in;
                cnt_nx   = cnt + 4'd1;
                stall_nx = '0;
            end else begin
                stall_nx = stall + 8'd1;
            end
            TRAILER: begin
                bus_nx   = {4'hE, seq, csum};
                valid_nx = 1'b1;
                seq_nx   = seq + 4'd1;
            end
            default: begin
                bus_nx   = {4'hB, seq, 8'hFF};
                valid_nx = 1'b1;
                err_nx   = 1'b1;
                seq_nx   = seq + 4'd1;
            end
        endcase
    end

    // registered outputs and packet bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_data_out <= '0;
            bus_valid    <= 1'b0;
            error        <= 1'b0;
            seq          <= '0;
            cnt          <= '0;
            csum         <= '0;
            stall        <= '0;
        end else begin
            bus_data_out <= bus_nx;
            bus_valid    <= valid_nx;
            error        <= err_nx;
            seq          <= seq_nx;
            cnt          <= cnt_nx;
            csum         <= csum_nx;
            stall        <= stall_nx;
        end
    end
endmodule

// File: tb/tb_fsm_par_framer.sv
// tb_fsm_par_framer: randomized packet-level checks of fsm_par_framer against a frame model
module tb_fsm_par_framer;
    localparam int L  = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [15:0] bus_data_out;
    logic        bus_valid;
    logic [1:0]  state;
    logic        error;

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0]  pb[16];
    int          ps[16];
    logic [20:0] exp_q[$], obs_q[$];
    logic [3:0]  m_seq = '0;
    logic        m_err = 1'b0;

    fsm_par_framer #(.PKT_LEN(L), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .bus_data_out(bus_data_out), .bus_valid(bus_valid),
        .state(state), .error(error)
    );

    always #5 clk = ~clk;

    // record layout: {bus_valid, state[1:0], error, data_ready, bus_data_out[15:0]}
    function automatic logic [20:0] pk(input logic v, input logic [1:0] s, input logic er,
                                       input logic r, input logic [15:0] w);
        return {v, s, er, r, w};
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic [20:0] e);
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        #1;
        obs_q.push_back({bus_valid, state, error, data_ready, bus_data_out});
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_seq = '0;
        m_err = 1'b0;
    endtask

    // frame model: header, per-byte stalls then data words, then trailer or abort
    task automatic run_pkt(input int gap);
        logic [7:0] cs;
        for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), pk(0, 0, m_err, 0, 0));
        m_err = 1'b0;
        step(1'b1, pb[0], pk(1, 1, 0, 1, {4'hA, m_seq, 4'h0, 4'(L)}));
        cs = '0;
        for (int i = 0; i < L; i++) begin
            for (int k = 0; k < ps[i]; k++) begin
                if (k + 1 == TO) begin
                    step(1'b0, 8'($urandom), pk(0, 3, 0, 0, 0));
                    step(1'($urandom), 8'($urandom), pk(1, 0, 1, 0, {4'hB, m_seq, 8'hFF}));
                    m_seq = m_seq + 4'd1;
                    m_err = 1'b1;
                    return;
                end
                step(1'b0, 8'($urandom), pk(0, 1, 0, 1, 0));
            end
            cs = cs + pb[i];
            step(1'b1, pb[i], pk(1, (i == L-1) ? 2'd2 : 2'd1, 0, (i == L-1) ? 1'b0 : 1'b1,
                                 {4'h5, 3'b000, ^pb[i], pb[i]}));
        end
        step(1'($urandom), 8'($urandom), pk(1, 0, 0, 0, {4'hE, m_seq, cs}));
        m_seq = m_seq + 4'd1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_valid = 1'($urandom);
            data_in    = 8'($urandom);
            #1;
            n_chk++;
            if ({bus_valid, state, error, data_ready, bus_data_out} !== 21'h0)
                $display("FAIL reset[%0d] got %h want 000000", i,
                         {bus_valid, state, error, data_ready, bus_data_out});
            else n_pass++;
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        data_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] lit[6];
        lit = '{16'hA004, 16'h5101, 16'h5003, 16'h5107, 16'h50FF, 16'hE00A};
        exp_q.delete(); obs_q.delete();
        pb[0] = 8'h01; pb[1] = 8'h03; pb[2] = 8'h07; pb[3] = 8'hFF;
        for (int i = 0; i < 16; i++) ps[i] = 0;
        run_pkt(1);
        step(1'b0, 8'h00, pk(0, 0, 0, 0, 0));
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL basic[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if ({obs_q[i+1][20], obs_q[i+1][15:0]} !== {1'b1, lit[i]})
                $display("FAIL basic_word[%0d] got %h want 1%h", i, {obs_q[i+1][20], obs_q[i+1][15:0]}, lit[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); obs_q.delete();
        do_reset();
        for (int i = 0; i < 16; i++) ps[i] = 0;
        pb[0] = 8'h01; pb[1] = 8'h03; pb[2] = 8'h07; pb[3] = 8'hFF;
        run_pkt(0);
        pb[0] = 8'h10; pb[1] = 8'h20; pb[2] = 8'h30; pb[3] = 8'h40;
        run_pkt(0);
        step(1'b0, 8'h00, pk(0, 0, 0, 0, 0));
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_chk++;
        if ({obs_q[5][15:0], obs_q[6][15:0], obs_q[11][15:0]} !== {16'hE00A, 16'hA104, 16'hE1A0})
            $display("FAIL b2b_words got %h %h %h want e00a a104 e1a0",
                     obs_q[5][15:0], obs_q[6][15:0], obs_q[11][15:0]);
        else n_pass++;
        for (int i = 0; i < 13; i++) begin
            n_chk++;
            if (obs_q[i][20] !== (i < 12)) $display("FAIL b2b_valid[%0d] got %b want %b", i, obs_q[i][20], i < 12);
            else n_pass++;
        end
    endtask

    task automatic test_stall_short();
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 16; i++) begin pb[i] = 8'($urandom); ps[i] = 0; end
        ps[2] = 3;
        run_pkt(1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL stall3[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        exp_q.delete(); obs_q.delete();
        do_reset();
        for (int i = 0; i < 16; i++) begin pb[i] = 8'($urandom); ps[i] = 0; end
        ps[2] = TO;
        run_pkt(0);
        ps[2] = 0;
        run_pkt(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL abort[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_chk++;
        if ({obs_q[11][20], obs_q[11][17], obs_q[11][15:0]} !== {2'b11, 16'hB0FF})
            $display("FAIL abort_word got v%b e%b %h want v1 e1 b0ff", obs_q[11][20], obs_q[11][17], obs_q[11][15:0]);
        else n_pass++;
        n_chk++;
        if ({obs_q[12][17], obs_q[12][15:0]} !== {1'b0, 16'hA104})
            $display("FAIL abort_next_hdr got e%b %h want e0 a104", obs_q[12][17], obs_q[12][15:0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 16; i++) begin pb[i] = 8'($urandom); ps[i] = 0; end
        step(1'b1, pb[0], pk(1, 1, 0, 1, {4'hA, m_seq, 4'h0, 4'(L)}));
        step(1'b1, pb[0], pk(1, 1, 0, 1, {4'h5, 3'b000, ^pb[0], pb[0]}));
        step(1'b1, pb[1], pk(1, 1, 0, 1, {4'h5, 3'b000, ^pb[1], pb[1]}));
        data_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({bus_valid, state, error, data_ready, bus_data_out} !== 21'h0)
            $display("FAIL reset_mid got %h want 000000", {bus_valid, state, error, data_ready, bus_data_out});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_seq = '0;
        m_err = 1'b0;
        run_pkt(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL reset_mid[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_chk++;
        if (obs_q[3][15:0] !== 16'hA004) $display("FAIL reset_mid_hdr got %h want a004", obs_q[3][15:0]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int p = 0; p < 25; p++) begin
            exp_q.delete(); obs_q.delete();
            for (int i = 0; i < 16; i++) begin
                pb[i] = 8'($urandom);
                ps[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 2));
            end
            run_pkt(int'($urandom_range(0, 2)));
            for (int i = 0; i < exp_q.size(); i++) begin
                n_chk++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL random[%0d][%0d] got %h want %h", p, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall_short();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fsm_par_framer.md
# fsm_par_framer

Transmit-side framer for the 16-bit parity-checked bus consumed by `fsm_par_mux`. It takes a byte stream with a valid/ready handshake and emits one 16-bit word per cycle: a header, then one parity-tagged data word per byte, then a checksum trailer. If the source stalls too long, it emits an abort word instead. It sits upstream of the receiver and drives its `bus_data_in`.

## Interface
- `PKT_LEN`, 4: payload bytes per packet; legal range 1..15; carried in the header length field.
- `TIMEOUT`, 8: consecutive stalled cycles in DATA that trigger an abort; legal range 1..255.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; low forces all state and outputs to reset values immediately
- `data_in`  in  8  payload byte
- `data_valid`  in  1  source has a byte on `data_in`
- `data_ready`  out  1  combinational; high only in DATA state
- `bus_data_out`  out  16  registered framed word
- `bus_valid`  out  1  registered; `bus_data_out` carries a word this cycle
- `state`  out  2  registered FSM state: IDLE=0, DATA=1, TRAILER=2, ABORT=3
- `error`  out  1  registered, sticky; set by an abort, cleared when the next header is emitted

## Operation
- Word formats (`seq` is a 4-bit packet counter, `par` is `^byte`, i.e. even parity):
  - HEADER = {4'hA, seq, 4'h0, PKT_LEN[3:0]}
  - DATA = {4'h5, 3'b000, par, byte}
  - TRAILER = {4'hE, seq, csum}, where `csum` is the sum of the packet's bytes mod 256
  - ABORT = {4'hB, seq, 8'hFF}
- A byte is accepted on a rising edge where `data_valid & data_ready` is high.
- IDLE:
  - `data_ready`=0.
  - Edge with `data_valid`=1: emit HEADER, clear `error`, clear byte count, `csum` and stall count, go to DATA.
  - Otherwise: `bus_valid`<=0, `bus_data_out`<=0.
- DATA:
  - Accepting edge: emit the DATA word, `csum`+=byte, count++, clear the stall count.
    - If this is byte PKT_LEN-1, go to TRAILER.
  - Edge with `data_valid`=0: `bus_valid`<=0, `bus_data_out`<=0.
    - If stall count == TIMEOUT-1, go to ABORT; otherwise increment the stall count.
- TRAILER: next edge emits TRAILER (using the fully updated `csum`), `seq`++ (wraps 15->0), go to IDLE.
- ABORT: next edge emits ABORT, `error`<=1, `seq`++, go to IDLE; the partial `csum` is discarded.
- `data_valid` in IDLE, TRAILER or ABORT never accepts a byte (`data_ready`=0). The byte stays pending at the source.

## Timing
- Reset values: `bus_data_out`=16'h0000, `bus_valid`=0, `state`=0, `error`=0, `seq`=0, all counters 0, `data_ready`=0.
- Reset mid-packet: outputs clear immediately, asynchronously. No trailer or abort word is emitted. The first packet after release uses `seq`=0.
- HEADER appears on the bus 1 cycle after the first edge that sees `data_valid`=1 in IDLE.
- Each DATA word appears 1 cycle after its accepting edge. TRAILER appears on the cycle after the last DATA word.
- With `data_valid` held high, a packet occupies exactly PKT_LEN+2 consecutive `bus_valid` cycles.
- Back-to-back packets run with no gap: TRAILER is followed directly by the next HEADER.
- Stalls produce `bus_valid`=0 bubbles. ABORT is emitted after exactly TIMEOUT consecutive stalled edges plus 1 cycle.
- `error` rises with the ABORT word and falls with the next HEADER word.

## Test plan
- Reset: hold `reset`=0 with random inputs -> `bus_data_out`=0, `bus_valid`=0, `state`=0, `error`=0, `data_ready`=0.
- PKT_LEN=4, bytes 0x01, 0x03, 0x07, 0xFF with continuous valid -> words 0xA004, 0x5101, 0x5003, 0x5107, 0x50FF, 0xE00A on 6 consecutive cycles, then `bus_valid`=0.
- Immediate second packet of bytes 0x10, 0x20, 0x30, 0x40 -> 0xA104 directly after 0xE00A, trailer 0xE1A0.
- Stall of 3 cycles after byte 2 (TIMEOUT=8) -> 3 bubble cycles, packet completes with the correct trailer, `error` stays 0.
- Stall of 8 cycles after byte 2 -> 0xB0FF is emitted and `error`=1. The next packet header is 0xA104 and clears `error`.
- Assert `reset` after 2 data words -> outputs clear immediately. After release the next packet starts with 0xA004.
